// File: rtl/image_pkg.sv
// Shared types and constants for the image writer and its pixel counter.
// Build option: define GRAY_ONLY_EN for one byte per pixel (R channel only).
package image_pkg;

    localparam int DEFAULT_HEIGHT = 120;
    localparam int DEFAULT_WIDTH  = 160;

`ifdef GRAY_ONLY_EN
    localparam int BYTES_PER_PIXEL = 1;

    // Grayscale build: a single write state per pixel.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WR_R   = 3'd2,
        ST_DONE   = 3'd5
    } wr_state_e;
`else
    localparam int BYTES_PER_PIXEL = 3;

    // RGB build: three write states serialise one pixel.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WR_R   = 3'd2,
        ST_WR_G   = 3'd3,
        ST_WR_B   = 3'd4,
        ST_DONE   = 3'd5
    } wr_state_e;
`endif

    // Byte address of the first byte of pixel idx in the frame memory.
    function automatic logic [31:0] pixel_byte_addr(input logic [31:0] idx);
        return idx * 32'(BYTES_PER_PIXEL);
    endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster position tracker: row/col of the next pixel plus a linear index.
// Columns wrap at width-1 and carry into the row; after the final pixel the
// position rests at row=height, col=0. Shared with the reader side.
module pixel_counter import image_pkg::*; #(
    parameter int height = DEFAULT_HEIGHT,
    parameter int width  = DEFAULT_WIDTH,
    parameter int IDX_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [15:0]      row,
    output logic [15:0]      col,
    output logic [IDX_W-1:0] index,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(height * width - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [15:0]      LAST_COL  = 16'(width - 1);

    // Step the raster position once per accepted pixel; clear re-arms a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            row   <= 16'd0;
            col   <= 16'd0;
            index <= IDX_ZERO;
        end else if (clear) begin
            row   <= 16'd0;
            col   <= 16'd0;
            index <= IDX_ZERO;
        end else if (advance) begin
            index <= index + IDX_ONE;
            if (col == LAST_COL) begin
                col <= 16'd0;
                row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end else begin
            row   <= row;
            col   <= col;
            index <= index;
        end
    end

    // The pixel about to be accepted is the final one of the frame.
    assign last = (index == LAST_IDX);

endmodule

// File: rtl/image_writer.sv
// Pixel-stream sink: takes one pixel per valid/ready handshake and writes it
// to byte-wide frame memory as interleaved R,G,B (the reader's layout).
// Build option: GRAY_ONLY_EN writes only data_r, one byte per pixel, and can
// accept a pixel every cycle.
module image_writer import image_pkg::*; #(
    parameter int height = DEFAULT_HEIGHT,
    parameter int width  = DEFAULT_WIDTH,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        data_r,
    input  logic [7:0]        data_g,
    input  logic [7:0]        data_b,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
`ifndef GRAY_ONLY_EN
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);
`endif

    wr_state_e         state_r;
    logic [ADDR_W-1:0] idx_s;
    logic [ADDR_W-1:0] base_addr_s;
    logic              last_s;
    logic              handshake_s;
    logic              clear_s;
    logic              last_pix_r;
`ifndef GRAY_ONLY_EN
    logic [7:0]        g_r;
    logic [7:0]        b_r;
`endif

    // pix_ready is only ever high in states that may take a pixel.
    assign handshake_s = pix_valid & pix_ready;
    assign clear_s     = (state_r == ST_IDLE) & start;
    assign base_addr_s = ADDR_W'(pixel_byte_addr(32'(idx_s)));

    pixel_counter #(
        .height (height),
        .width  (width),
        .IDX_W  (ADDR_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .advance (handshake_s),
        .row     (row),
        .col     (col),
        .index   (idx_s),
        .last    (last_s)
    );

    // Writer FSM: sequences byte writes and drives all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pix_ready  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= ADDR_ZERO;
            mem_wdata  <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            last_pix_r <= 1'b0;
`ifndef GRAY_ONLY_EN
            g_r        <= 8'h00;
            b_r        <= 8'h00;
`endif
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_ACCEPT;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ACCEPT: begin
                    // Left only through the handshake path below.
                    state_r <= ST_ACCEPT;
                end
`ifdef GRAY_ONLY_EN
                ST_WR_R: begin
                    if (last_pix_r) begin
                        state_r    <= ST_DONE;
                        pix_ready  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        state_r    <= ST_ACCEPT;
                    end
                end
`else
                ST_WR_R: begin
                    state_r   <= ST_WR_G;
                    mem_we    <= 1'b1;
                    mem_addr  <= mem_addr + ADDR_ONE;
                    mem_wdata <= g_r;
                end
                ST_WR_G: begin
                    state_r   <= ST_WR_B;
                    mem_we    <= 1'b1;
                    mem_addr  <= mem_addr + ADDR_ONE;
                    mem_wdata <= b_r;
                    // Overlap the next handshake with the B write unless done.
                    pix_ready <= ~last_pix_r;
                end
                ST_WR_B: begin
                    if (last_pix_r) begin
                        state_r    <= ST_DONE;
                        pix_ready  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        state_r    <= ST_ACCEPT;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase

            // A handshake always starts the R write of the accepted pixel,
            // whichever accepting state it happened in.
            if (handshake_s) begin
                state_r    <= ST_WR_R;
                mem_we     <= 1'b1;
                mem_addr   <= base_addr_s;
                mem_wdata  <= data_r;
                last_pix_r <= last_s;
`ifdef GRAY_ONLY_EN
                pix_ready  <= ~last_s;
`else
                pix_ready  <= 1'b0;
                g_r        <= data_g;
                b_r        <= data_b;
`endif
            end
        end
    end

endmodule

// File: tb/tb_image_writer.sv
// Self-checking bench for image_writer: scoreboard of expected byte writes,
// one task per scenario.
module tb_image_writer;

    localparam int H    = 120;
    localparam int W    = 160;
    localparam int NPIX = H * W;
`ifdef GRAY_ONLY_EN
    localparam int BPP  = 1;
`else
    localparam int BPP  = 3;
`endif
    localparam int LAST_ADDR = NPIX * BPP - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  data_r = 8'h00;
    logic [7:0]  data_g = 8'h00;
    logic [7:0]  data_b = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] row;
    logic [15:0] col;
    logic        busy;
    logic        frame_done;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [23:0] exp_q[$];

    image_writer #(.height(H), .width(W), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .data_r(data_r), .data_g(data_g), .data_b(data_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .row(row), .col(col), .busy(busy), .frame_done(frame_done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle counter used for latency/spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Expected bytes of one accepted pixel, in write order.
    task automatic push_pixel(input int p, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [7:0] bytes [3];
        bytes[0] = r; bytes[1] = g; bytes[2] = b;
        for (int k = 0; k < BPP; k++) exp_q.push_back({16'(p * BPP + k), bytes[k]});
    endtask

    task automatic randomize_data();
        data_r = 8'($urandom_range(0, 255));
        data_g = 8'($urandom_range(0, 255));
        data_b = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b1; randomize_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({pix_ready, mem_we, busy, frame_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got ready/we/busy/done=%b expected 0000", {pix_ready, mem_we, busy, frame_done});
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: got addr=%0d data=%h expected 0/00", mem_addr, mem_wdata);
        end
        tests_run++;
        if ({row, col} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pos: got row=%0d col=%0d expected 0/0", row, col);
        end
        @(posedge clk); #1 rst = 1'b0;
        // pix_valid high in IDLE without start must be ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if ({pix_ready, mem_we} !== 2'b00) begin
                tests_failed++;
                $display("FAIL idle_ignores_valid: got ready/we=%b expected 00", {pix_ready, mem_we});
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_first_pixel();
        logic [23:0] e;
        do_reset();
        do_start();
        @(negedge clk);
        tests_run++;
        if ({pix_ready, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL start_ready: got ready/busy=%b expected 11", {pix_ready, busy});
        end
        data_r = 8'h12; data_g = 8'h34; data_b = 8'h56; pix_valid = 1'b1;
        push_pixel(0, 8'h12, 8'h34, 8'h56);
        @(posedge clk); #1;
        pix_valid = 1'b0; data_r = 8'hFF; data_g = 8'hFF; data_b = 8'hFF;
        for (int k = 0; k < BPP; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, e}) begin
                tests_failed++;
                $display("FAIL first_pixel_byte%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         k, mem_we, mem_addr, mem_wdata, e[23:8], e[7:0]);
            end
            if (k == 0) begin
                tests_run++;
                if ({row, col} !== {16'd0, 16'd1}) begin
                    tests_failed++;
                    $display("FAIL first_pixel_col: got row=%0d col=%0d expected 0/1", row, col);
                end
            end
            if (k == BPP - 1) begin
                tests_run++;
                if (pix_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL first_pixel_ready_overlap: got %b expected 1", pix_ready);
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if ({mem_we, pix_ready, busy} !== 3'b011) begin
            tests_failed++;
            $display("FAIL first_pixel_after: got we/ready/busy=%b expected 011", {mem_we, pix_ready, busy});
        end
    endtask

    task automatic test_full_frame();
        logic [23:0] e;
        int p = 0, hs_count = 0, prev_hs = 0, spacing_bad = 0;
        int last_we_cyc = -10, done_cyc = -1;
        logic [15:0] last_addr = 16'd0;
        logic done_seen = 1'b0, busy_at_done = 1'b1, chk_wrap = 1'b0, hs;
        do_reset();
        do_start();
        pix_valid = 1'b1; randomize_data();
        for (int t = 0; t < NPIX * BPP + 40 && !done_seen; t++) begin
            @(negedge clk);
            if (mem_we) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL frame_unexpected_write: got addr=%0d data=%h expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        tests_failed++;
                        $display("FAIL frame_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 mem_addr, mem_wdata, e[23:8], e[7:0]);
                    end
                end
                if (chk_wrap) begin
                    chk_wrap = 1'b0;
                    tests_run++;
                    if (mem_addr !== 16'(160 * BPP)) begin
                        tests_failed++;
                        $display("FAIL row_wrap_addr: got %0d expected %0d", mem_addr, 160 * BPP);
                    end
                end
                last_we_cyc = cyc;
                last_addr = mem_addr;
            end
            if (frame_done) begin
                done_seen = 1'b1; done_cyc = cyc; busy_at_done = busy;
            end
            hs = pix_valid && pix_ready;
            if (hs) begin
                if (hs_count > 0 && (cyc - prev_hs) != BPP) spacing_bad++;
                prev_hs = cyc;
                if (p == 159) begin
                    tests_run++;
                    if ({row, col} !== {16'd0, 16'd159}) begin
                        tests_failed++;
                        $display("FAIL pos_pixel159: got row=%0d col=%0d expected 0/159", row, col);
                    end
                end
                if (p == 160) begin
                    chk_wrap = 1'b1;
                    tests_run++;
                    if ({row, col} !== {16'd1, 16'd0}) begin
                        tests_failed++;
                        $display("FAIL row_wrap_pos: got row=%0d col=%0d expected 1/0", row, col);
                    end
                end
                push_pixel(p, data_r, data_g, data_b);
            end
            @(posedge clk); #1;
            if (hs) begin
                p++; hs_count++; randomize_data();
            end
        end
        tests_run++;
        if (!done_seen) begin
            tests_failed++;
            $display("FAIL frame_done_timeout: got no frame_done expected one within budget");
        end
        tests_run++;
        if (last_addr !== 16'(LAST_ADDR)) begin
            tests_failed++;
            $display("FAIL frame_last_addr: got %0d expected %0d", last_addr, LAST_ADDR);
        end
        tests_run++;
        if (done_cyc != last_we_cyc + 1) begin
            tests_failed++;
            $display("FAIL frame_done_latency: got cycle %0d expected %0d", done_cyc, last_we_cyc + 1);
        end
        tests_run++;
        if (busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_busy_at_done: got %b expected 0", busy_at_done);
        end
        tests_run++;
        if (hs_count != NPIX || spacing_bad != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL frame_handshakes: got count=%0d bad_spacing=%0d pending=%0d expected %0d/0/0",
                     hs_count, spacing_bad, exp_q.size(), NPIX);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({frame_done, busy, pix_ready, mem_we, row, col} !== {4'b0000, 16'(H), 16'd0}) begin
                tests_failed++;
                $display("FAIL frame_after_done: got done/busy/ready/we=%b row=%0d col=%0d expected 0000 row=%0d col=0",
                         {frame_done, busy, pix_ready, mem_we}, row, col, H);
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_random_valid();
        logic [23:0] e;
        int p = 0, writes = 0;
        logic hs;
        do_reset();
        do_start();
        pix_valid = 1'($urandom_range(0, 1)); randomize_data();
        for (int t = 0; t < 900; t++) begin
            @(negedge clk);
            if (mem_we) begin
                writes++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL random_unexpected_write: got addr=%0d data=%h expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        tests_failed++;
                        $display("FAIL random_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 mem_addr, mem_wdata, e[23:8], e[7:0]);
                    end
                end
            end
            hs = pix_valid && pix_ready;
            if (hs) push_pixel(p, data_r, data_g, data_b);
            @(posedge clk); #1;
            if (hs) p++;
            if (hs || !pix_valid) begin
                pix_valid = 1'($urandom_range(0, 1));
                randomize_data();
            end
        end
        pix_valid = 1'b0;
        for (int i = 0; i < BPP + 2; i++) begin
            @(negedge clk);
            if (mem_we) begin
                writes++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL random_drain_write: got addr=%0d expected no write", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        tests_failed++;
                        $display("FAIL random_drain: got addr=%0d data=%h expected addr=%0d data=%h",
                                 mem_addr, mem_wdata, e[23:8], e[7:0]);
                    end
                end
            end
        end
        tests_run++;
        if (writes != p * BPP || exp_q.size() != 0 || p < 50) begin
            tests_failed++;
            $display("FAIL random_totals: got writes=%0d pixels=%0d pending=%0d expected writes=pixels*%0d, none pending",
                     writes, p, exp_q.size(), BPP);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] e;
        int p = 0;
        int target = 5 * BPP + ((BPP > 1) ? 1 : 0);
        logic hit = 1'b0, hs;
        do_reset();
        do_start();
        pix_valid = 1'b1; randomize_data();
        for (int t = 0; t < 100 && !hit; t++) begin
            @(negedge clk);
            hs = 1'b0;
            if (mem_we) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({mem_addr, mem_wdata} !== e) begin
                    tests_failed++;
                    $display("FAIL midrst_write: got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e[23:8], e[7:0]);
                end
                if (mem_addr == 16'(target)) hit = 1'b1;
            end
            if (hit) begin
                rst = 1'b1;
            end else begin
                hs = pix_valid && pix_ready;
                if (hs) push_pixel(p, data_r, data_g, data_b);
            end
            @(posedge clk); #1;
            if (hs) begin
                p++; randomize_data();
            end
        end
        rst = 1'b0;
        exp_q.delete();
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL midrst_timeout: got no write to addr %0d expected one", target);
        end
        @(negedge clk);
        tests_run++;
        if ({pix_ready, mem_we, mem_addr, mem_wdata, row, col, busy, frame_done} !== 60'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got ready=%b we=%b addr=%0d data=%h row=%0d col=%0d busy=%b done=%b expected all 0",
                     pix_ready, mem_we, mem_addr, mem_wdata, row, col, busy, frame_done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if ({mem_we, frame_done, pix_ready} !== 3'b000) begin
                tests_failed++;
                $display("FAIL midrst_quiet: got we/done/ready=%b expected 000", {mem_we, frame_done, pix_ready});
            end
        end
        pix_valid = 1'b0;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_first_pixel();
        test_reset_mid_frame();
        test_random_valid();
        test_full_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
